uart_tx: RTL and testbench

Serial UART transmitter that drains the Wishbone-to-UART transmit FIFO and serialises each byte onto `txd` as 8N1, or 8E1 with parity enabled. It sits directly downstream of the TX byte FIFO. It drives the FIFO's `pop` and samples its registered `data_out` one cycle later. It owns the only TX pin of the bridge.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_cnt.sv | 33 +++
 rtl/uart_tx.sv | 114 +++++++++++
 tb/tb_uart_tx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding, data width, default bit divider.
// Parity state is present only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam int unsigned UART_DATA_W      = 8;
   localparam int unsigned UART_CLK_DIV_DEF = 868;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_POP    = 3'd1,
      ST_LOAD   = 3'd2,
      ST_START  = 3'd3,
      ST_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd5,
`endif
      ST_STOP   = 3'd6
   } uart_tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period divider: counts 0..CLK_DIV-1 and wraps, flagging bit_end on the last count.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV = UART_CLK_DIV_DEF,
   parameter int unsigned DIV_WID = 16
) (
   input  logic clk,
   input  logic nrst,
   input  logic clr,
   output logic bit_end
);

   logic [DIV_WID-1:0] cnt_q, cnt_d;

   assign bit_end = (cnt_q == DIV_WID'(CLK_DIV - 1));

   always_comb begin
      cnt_d = cnt_q + DIV_WID'(1);
      if (clr || bit_end) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining the TX byte FIFO onto txd as 8N1.
// Defining UART_TX_PARITY_EN adds an even-parity bit (8E1).
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV = UART_CLK_DIV_DEF,
   parameter int unsigned DIV_WID = 16
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   fifo_empty,
   output logic                   fifo_pop,
   input  logic [UART_DATA_W-1:0] fifo_data,
   output logic                   txd,
   output logic                   busy
);

   uart_tx_state_e         state_q, state_d;
   logic [UART_DATA_W-1:0] shreg_q, shreg_d;
   logic [2:0]             bit_idx_q, bit_idx_d;
   logic                   txd_q, txd_d;
   logic                   bit_end;
   logic                   div_clr;
`ifdef UART_TX_PARITY_EN
   logic                   parity_q, parity_d;
`endif

   assign div_clr  = (state_q inside {ST_IDLE, ST_POP, ST_LOAD});
   assign fifo_pop = (state_q == ST_POP);
   assign busy     = (state_q != ST_IDLE);
   assign txd      = txd_q;

   uart_baud_cnt #(
      .CLK_DIV (CLK_DIV),
      .DIV_WID (DIV_WID)
   ) u_baud (
      .clk     (clk),
      .nrst    (nrst),
      .clr     (div_clr),
      .bit_end (bit_end)
   );

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         ST_IDLE:  if (!fifo_empty) state_d = ST_POP;
         ST_POP:   state_d = ST_LOAD;
         ST_LOAD: begin
            shreg_d   = fifo_data;
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^fifo_data;
`endif
            state_d   = ST_START;
         end
         ST_START: if (bit_end) state_d = ST_DATA;
         ST_DATA: begin
            if (bit_end) begin
               shreg_d = {1'b0, shreg_q[UART_DATA_W-1:1]};
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
         ST_STOP:  if (bit_end) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // txd is registered from the upcoming state so the line changes on the transition edge.
      case (state_d)
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: txd_d = parity_q;
`endif
         default:   txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_idx_q <= '0;
         txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_idx_q <= bit_idx_d;
         txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLK_DIV=4 with a registered-output FIFO model.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       fifo_empty;
   logic       fifo_pop;
   logic [7:0] fifo_data = 8'h00;
   logic       txd;
   logic       busy;

   logic [7:0] mem [0:15];
   int         wr_idx = 0;
   int         rd_idx = 0;
   int         errors = 0;
   int         checks = 0;

`ifdef UART_TX_PARITY_EN
   localparam string F55 = "01010101001";
   localparam string FA3 = "01100010101";
   localparam string F0F = "01111000001";
   localparam string F3C = "00011110001";
   localparam string F07 = "01110000011";
`else
   localparam string F55 = "0101010101";
   localparam string FA3 = "0110001011";
   localparam string F0F = "0111100001";
   localparam string F3C = "0001111001";
`endif

   always #5 clk = ~clk;

   uart_tx #(
      .CLK_DIV (4),
      .DIV_WID (16)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .fifo_empty (fifo_empty),
      .fifo_pop   (fifo_pop),
      .fifo_data  (fifo_data),
      .txd        (txd),
      .busy       (busy)
   );

   assign fifo_empty = (wr_idx == rd_idx);

   always @(posedge clk) begin
      if (fifo_pop) begin
         fifo_data <= mem[rd_idx[3:0]];
         rd_idx    <= rd_idx + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_idx[3:0]] = b;
      wr_idx++;
   endtask

   // Returns the number of falling-edge samples up to and including the first txd=0.
   task automatic wait_fall(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (txd !== 1'b0 && n < 200);
      if (txd !== 1'b0) check("start bit timeout", 32'(txd), 32'd0);
   endtask

   task automatic check_frame(input string tag, input string bits);
      for (int b = 0; b < bits.len(); b++) begin
         for (int c = 0; c < 4; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            check($sformatf("%s txd bit%0d c%0d", tag, b, c), 32'(txd),
                  (bits.getc(b) == "1") ? 32'd1 : 32'd0);
            check($sformatf("%s busy bit%0d", tag, b), 32'(busy), 32'd1);
         end
      end
   endtask

   initial begin
      int n;
      int pops_before;
      bit seen_pop;
      bit seen_low;

      repeat (5) begin
         @(negedge clk);
         check("rst txd", 32'(txd), 32'd1);
         check("rst busy", 32'(busy), 32'd0);
         check("rst pop", 32'(fifo_pop), 32'd0);
      end
      nrst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post-rst txd", 32'(txd), 32'd1);
         check("post-rst busy", 32'(busy), 32'd0);
         check("post-rst pop", 32'(fifo_pop), 32'd0);
      end

      push(8'h55);
      wait_fall(n);
      check("first start latency", 32'(n), 32'd3);
      check_frame("b55", F55);
      @(negedge clk);
      check("b55 busy after", 32'(busy), 32'd0);
      check("b55 txd after", 32'(txd), 32'd1);
      check("b55 pops", 32'(rd_idx), 32'd1);

      push(8'hA3);
      push(8'h0F);
      wait_fall(n);
      check("bA3 start latency", 32'(n), 32'd3);
      check_frame("bA3", FA3);
      wait_fall(n);
      check("back-to-back gap", 32'(n - 1), 32'd3);
      check_frame("b0F", F0F);
      @(negedge clk);
      check("b0F busy after", 32'(busy), 32'd0);
      check("two-byte pops", 32'(rd_idx), 32'd3);

`ifdef UART_TX_PARITY_EN
      push(8'h07);
      wait_fall(n);
      check_frame("b07", F07);
      @(negedge clk);
      check("b07 busy after 44", 32'(busy), 32'd0);
      check("b07 txd after", 32'(txd), 32'd1);
`endif

      push(8'hFF);
      wait_fall(n);
      repeat (16) @(negedge clk);
      check("bFF bit3 txd", 32'(txd), 32'd1);
      check("bFF bit3 busy", 32'(busy), 32'd1);
      pops_before = rd_idx;
      nrst = 1'b0;
      push(8'h3C);
      @(negedge clk);
      check("midrst txd", 32'(txd), 32'd1);
      check("midrst busy", 32'(busy), 32'd0);
      repeat (4) begin
         @(negedge clk);
         check("midrst held pop", 32'(fifo_pop), 32'd0);
         check("midrst held txd", 32'(txd), 32'd1);
      end
      check("midrst no pop", 32'(rd_idx), 32'(pops_before));
      nrst = 1'b1;
      wait_fall(n);
      check("post-midrst latency", 32'(n), 32'd3);
      check_frame("b3C", F3C);
      @(negedge clk);
      check("b3C busy after", 32'(busy), 32'd0);
      check("post-midrst pops", 32'(rd_idx), 32'(pops_before + 1));

      seen_pop = 1'b0;
      seen_low = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (fifo_pop) seen_pop = 1'b1;
         if (!txd) seen_low = 1'b1;
      end
      check("empty no pop", 32'(seen_pop), 32'd0);
      check("empty txd high", 32'(seen_low), 32'd0);
      check("empty busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
